// File: rtl/goldschmidt_pkg.sv
// Shared constants for the Goldschmidt divider: FSM state codes and fixed-point helpers.
package goldschmidt_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t MUL_N = 2'd1;
    localparam state_t MUL_D = 2'd2;
    localparam state_t DONE  = 2'd3;

    // 0.75 in Q2.(width-2): the seed reciprocal for a divisor in [1.0, 2.0).
    function automatic logic [63:0] k0(input int width);
        return 64'd3 << (width - 4);
    endfunction

    function automatic logic [63:0] two(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/goldschmidt_mul.sv
// Combinational truncating Q2.(WIDTH-2) multiply: full product shifted right by WIDTH-2.
module goldschmidt_mul #(
    parameter int WIDTH = 29
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] full;

    assign full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign p    = WIDTH'(full >> (WIDTH - 2));

endmodule

// File: rtl/goldschmidt_iter_div.sv
// Self-sequencing Goldschmidt divider: one shared multiplier alternates between n*k and d*k
// for ITERS iterations, with valid/ready handshakes on the operand and quotient sides.
module goldschmidt_iter_div
    import goldschmidt_pkg::*;
#(
    parameter int WIDTH = 29,
    parameter int ITERS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             div_zero
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready and valid are decoded from state alone, and a DONE result holds until taken.

    localparam int               IW      = $clog2(ITERS + 1);
    localparam logic [WIDTH-1:0] K0_VAL  = WIDTH'(k0(WIDTH));
    localparam logic [WIDTH-1:0] TWO_VAL = WIDTH'(two(WIDTH));
    localparam logic [IW-1:0]    LAST_IT = IW'(ITERS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [IW-1:0]    it_q, it_d;
    logic [IW-1:0]    it_inc;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_p;

    assign mul_a  = (state_q == MUL_D) ? d_q : n_q;
    assign it_inc = it_q + IW'(1);

    goldschmidt_mul #(.WIDTH(WIDTH)) u_mul (
        .a (mul_a),
        .b (k_q),
        .p (mul_p)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        k_d     = k_q;
        it_d    = it_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d    = numerator;
                    d_d    = denominator;
                    k_d    = K0_VAL;
                    it_d   = '0;
                    zero_d = (denominator == '0);
                    if (denominator == '0) begin
                        // Saturated quotient for x/0; skip the multiply sequence entirely.
                        n_d     = '1;
                        state_d = DONE;
                    end else begin
                        state_d = MUL_N;
                    end
                end
            end
            MUL_N: begin
                n_d     = mul_p;
                state_d = MUL_D;
            end
            MUL_D: begin
                d_d     = mul_p;
                k_d     = TWO_VAL - mul_p;
                it_d    = it_inc;
                state_d = (it_inc == LAST_IT) ? DONE : MUL_N;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            d_q     <= '0;
            k_q     <= '0;
            it_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            k_q     <= k_d;
            it_q    <= it_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = n_q;
    assign div_zero  = zero_q;

endmodule

// File: tb/tb_goldschmidt_iter_div.sv
// Directed bench for goldschmidt_iter_div (WIDTH=29, ITERS=3, plus an ITERS=1 instance).
module tb_goldschmidt_iter_div;
    import goldschmidt_pkg::*;

    localparam int W = 29;

    // Directed vectors: 1.5/1.0, 1.0/1.5, 1.75/1.25, (1+2^-27)/1.0 (truncation), 1.0/0.
    localparam logic [W-1:0] VN [5] = '{29'h0C000000, 29'h08000000, 29'h0E000000, 29'h08000001, 29'h08000000};
    localparam logic [W-1:0] VD [5] = '{29'h08000000, 29'h0C000000, 29'h0A000000, 29'h08000000, 29'h00000000};
    localparam logic [W-1:0] VQ [5] = '{29'h0BF40000, 29'h05550000, 29'h0B332800, 29'h07F80000, 29'h1FFFFFFF};
    localparam logic         VZ [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] numerator = '0;
    logic [W-1:0] denominator = '0;
    logic         in_ready, out_valid, div_zero;
    logic [W-1:0] quotient;
    logic         in_ready1, out_valid1, div_zero1;
    logic [W-1:0] quotient1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    goldschmidt_iter_div #(.WIDTH(W), .ITERS(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .numerator   (numerator),
        .denominator (denominator),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .div_zero    (div_zero)
    );

    goldschmidt_iter_div #(.WIDTH(W), .ITERS(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready1),
        .numerator   (numerator),
        .denominator (denominator),
        .out_valid   (out_valid1),
        .out_ready   (out_ready),
        .quotient    (quotient1),
        .div_zero    (div_zero1)
    );

    // One division on the ITERS=3 instance; lat counts negedges after the accept edge.
    task automatic run_div(input logic [W-1:0] num, input logic [W-1:0] den,
                           output logic [W-1:0] q, output logic dz, output int lat);
        int guard;
        @(negedge clk);
        numerator   = num;
        denominator = den;
        in_valid    = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            q = '0;
            dz = 1'b0;
            lat = -1;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        q  = quotient;
        dz = div_zero;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_cmp++;
        if (quotient !== '0) begin n_bad++; $display("FAIL reset_quotient: got %h required 0", quotient); end
        n_cmp++;
        if (div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_div_zero: got %b required 0", div_zero); end
        n_cmp++;
        if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d required %0d", dut.state_q, IDLE); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, in_ready1, out_valid1} !== 4'b1010) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %b required 1010", {in_ready, out_valid, in_ready1, out_valid1});
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] q;
        logic         dz;
        int           lat;
        for (int i = 0; i < 5; i++) begin
            run_div(VN[i], VD[i], q, dz, lat);
            n_cmp++;
            if (q !== VQ[i]) begin n_bad++; $display("FAIL dir%0d_quotient: got %h required %h", i, q, VQ[i]); end
            n_cmp++;
            if (dz !== VZ[i]) begin n_bad++; $display("FAIL dir%0d_div_zero: got %b required %b", i, dz, VZ[i]); end
            n_cmp++;
            if (lat !== (VZ[i] ? 1 : 7)) begin
                n_bad++;
                $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, (VZ[i] ? 1 : 7));
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        @(negedge clk);
        numerator   = VN[0];
        denominator = VD[0];
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== 7) begin n_bad++; $display("FAIL stall_latency: got %0d required 7", lat); end
        for (int i = 0; i < 5; i++) begin
            in_valid    = (i % 2 == 0);
            numerator   = VN[4];
            denominator = VD[4];
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, div_zero, quotient} !== {1'b1, 1'b0, 1'b0, VQ[0]}) begin
                n_bad++;
                $display("FAIL stall_hold%0d: got v=%b r=%b z=%b q=%h required v=1 r=0 z=0 q=%h",
                         i, out_valid, in_ready, div_zero, quotient, VQ[0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL stall_release: got r=%b v=%b required r=1 v=0", in_ready, out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL stall_no_accept: got r=%b v=%b required r=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_iters1();
        int           lat;
        int           guard;
        logic [W-1:0] q1;
        @(negedge clk);
        numerator   = VN[0];
        denominator = VD[0];
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        q1 = quotient1;
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL iters1_latency: got %0d required 3", lat); end
        n_cmp++;
        if (q1 !== 29'h09000000) begin n_bad++; $display("FAIL iters1_quotient: got %h required 09000000", q1); end
        out_ready = 1'b1;
        guard = 0;
        while (!(in_ready && in_ready1) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (guard >= 50) begin n_bad++; $display("FAIL iters1_drain: got timeout required both idle"); end
    endtask

    task automatic test_back_to_back();
        int           cyc;
        int           idx;
        int           got;
        int           acc_cyc[4];
        logic [W-1:0] e;
        logic [W-1:0] exp_q[$];
        cyc = 0;
        idx = 0;
        got = 0;
        out_ready = 1'b1;
        while (got < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_spurious: got q=%h required no result", quotient);
                end else begin
                    e = exp_q.pop_front();
                    if (quotient !== e) begin
                        n_bad++;
                        $display("FAIL b2b_result%0d: got %h required %h", got, quotient, e);
                    end
                end
                got++;
            end
            if (in_ready) begin
                if (idx < 4) begin
                    numerator   = VN[idx];
                    denominator = VD[idx];
                    in_valid    = 1'b1;
                    acc_cyc[idx] = cyc;
                    exp_q.push_back(VQ[idx]);
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d required 4", got); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (acc_cyc[i+1] - acc_cyc[i] !== 8) begin
                n_bad++;
                $display("FAIL b2b_spacing%0d: got %0d required 8", i, acc_cyc[i+1] - acc_cyc[i]);
            end
        end
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int           guard;
        int           lat;
        logic [W-1:0] q;
        logic         dz;
        @(negedge clk);
        numerator   = VN[0];
        denominator = VD[0];
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!(dut.state_q == MUL_D && dut.it_q == 2'd1) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 20) begin n_bad++; $display("FAIL reset_mid_reach: got timeout required MUL_D iteration 2"); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({dut.state_q, in_ready, out_valid} !== {IDLE, 2'b10}) begin
            n_bad++;
            $display("FAIL reset_mid_abort: got s=%0d r=%b v=%b required s=0 r=1 v=0", dut.state_q, in_ready, out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({dut.state_q, in_ready, out_valid} !== {IDLE, 2'b10}) begin
            n_bad++;
            $display("FAIL reset_mid_hold: got s=%0d r=%b v=%b required s=0 r=1 v=0", dut.state_q, in_ready, out_valid);
        end
        reset = 1'b0;
        run_div(VN[2], VD[2], q, dz, lat);
        n_cmp++;
        if (q !== VQ[2]) begin n_bad++; $display("FAIL reset_mid_after_q: got %h required %h", q, VQ[2]); end
        n_cmp++;
        if (lat !== 7) begin n_bad++; $display("FAIL reset_mid_after_lat: got %0d required 7", lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_iters1();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
